// File: rtl/vectored_int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_pkg
// Shared definitions for the vectored priority interrupt controller:
//   - default parameter values for channel count and vector layout
//   - channel mode encodings (edge / level)
//   - priority encoder (lowest set bit wins) returning found flag and index
// -----------------------------------------------------------------------------
package int_pkg;

    localparam int         DEF_N_CH       = 4;
    localparam int         DEF_VEC_W      = 8;
    localparam logic [7:0] DEF_VEC_BASE   = 8'hF0;
    localparam int         DEF_VEC_STRIDE = 1;

    // Largest channel count the priority encoder supports.
    localparam int MAX_CH = 16;

    localparam logic MODE_EDGE  = 1'b1;
    localparam logic MODE_LEVEL = 1'b0;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } prio_t;

    // Lowest-index set bit of vec; channel 0 carries the highest priority.
    function automatic prio_t prio_enc(input logic [MAX_CH-1:0] vec);
        prio_t res;
        res.found = 1'b0;
        res.idx   = 4'd0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = 4'(i);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vectored_int_ctrl_if.sv
// -----------------------------------------------------------------------------
// vectored_int_ctrl_if
// Groups the request, configuration and status signals of the interrupt
// controller.
//   int_src     : raw interrupt sources (asynchronous to the clock)
//   mask_in/we  : mask load (bit=1 blocks the channel)
//   mode_in/we  : mode load (bit=1 edge, bit=0 level)
//   ien         : global interrupt enable
//   int_ack     : controller accepts the current request (pulse)
//   int_eoi     : end of interrupt from the handler (pulse)
//   irq_pending : a serviceable request exists
//   irq_vec     : vector of the winning channel
//   pend_out    : pending register
//   in_service  : in-service register
// master = controller/CPU side, slave = interrupt controller.
// -----------------------------------------------------------------------------
interface vectored_int_ctrl_if
    import int_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int VEC_W = DEF_VEC_W
);
    logic [N_CH-1:0]  int_src;
    logic [N_CH-1:0]  mask_in;
    logic             mask_we;
    logic [N_CH-1:0]  mode_in;
    logic             mode_we;
    logic             ien;
    logic             int_ack;
    logic             int_eoi;
    logic             irq_pending;
    logic [VEC_W-1:0] irq_vec;
    logic [N_CH-1:0]  pend_out;
    logic [N_CH-1:0]  in_service;

    modport master (
        output int_src, mask_in, mask_we, mode_in, mode_we, ien, int_ack, int_eoi,
        input  irq_pending, irq_vec, pend_out, in_service
    );

    modport slave (
        input  int_src, mask_in, mask_we, mode_in, mode_we, ien, int_ack, int_eoi,
        output irq_pending, irq_vec, pend_out, in_service
    );
endinterface

// File: rtl/vectored_int_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// int_sync_edge
// One interrupt channel front end: three-flop synchroniser followed by the
// edge/level capture decision.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   src     : raw asynchronous source
//   mode    : MODE_EDGE or MODE_LEVEL (registered upstream)
//   capture : request to set the channel's pending bit at the next edge
// -----------------------------------------------------------------------------
module int_sync_edge
    import int_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    output logic capture
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchroniser chain; s3 keeps the previous synchronised value for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= src;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Capture decode: rising edge in edge mode, high level in level mode.
    always_comb begin
        if (mode == MODE_EDGE) begin
            capture = s2_r & ~s3_r;
        end else begin
            capture = s2_r;
        end
    end

endmodule

// File: rtl/vectored_int_ctrl.sv
// -----------------------------------------------------------------------------
// vectored_int_ctrl
// Vectored, nested priority interrupt controller for N_CH channels.
// Channel 0 has the highest priority. A request is presented when the
// lowest eligible (pending and unmasked) channel out-ranks the lowest
// in-service channel; int_ack moves it from pending to in-service and
// int_eoi retires the highest-priority in-service channel.
//   g_clk : clock, all state updates on the rising edge
//   g_clr : asynchronous active-high reset
//   bus   : request/config/status signals (see vectored_int_ctrl_if)
// -----------------------------------------------------------------------------
module vectored_int_ctrl
    import int_pkg::*;
#(
    parameter int               N_CH       = DEF_N_CH,
    parameter int               VEC_W      = DEF_VEC_W,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(DEF_VEC_BASE),
    parameter int               VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic                  g_clk,
    input  logic                  g_clr,
    vectored_int_ctrl_if.slave    bus
);

    logic [N_CH-1:0]  mask_r;
    logic [N_CH-1:0]  mode_r;
    logic [N_CH-1:0]  pending_r;
    logic [N_CH-1:0]  in_service_r;

    logic [N_CH-1:0]  capture_s;
    logic [N_CH-1:0]  elig_s;
    logic [N_CH-1:0]  win_oh_s;
    logic [N_CH-1:0]  cur_oh_s;
    logic [N_CH-1:0]  pending_nx_s;
    logic [N_CH-1:0]  in_service_nx_s;
    prio_t            win_s;
    prio_t            cur_s;
    logic [4:0]       win_lvl_s;
    logic [4:0]       cur_lvl_s;
    logic             irq_pending_s;
    logic             ack_take_s;
    logic             eoi_take_s;
    logic [31:0]      vec_sum_s;
    logic [VEC_W-1:0] irq_vec_s;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        int_sync_edge u_sync (
            .clk     (g_clk),
            .rst     (g_clr),
            .src     (bus.int_src[gi]),
            .mode    (mode_r[gi]),
            .capture (capture_s[gi])
        );
    end

    // Arbitration: winner, current service level and the outgoing request/vector.
    always_comb begin
        elig_s    = pending_r & ~mask_r;
        win_s     = prio_enc(MAX_CH'(elig_s));
        cur_s     = prio_enc(MAX_CH'(in_service_r));
        win_lvl_s = {1'b0, win_s.idx};
        if (cur_s.found) begin
            cur_lvl_s = {1'b0, cur_s.idx};
        end else begin
            // Nothing in service: every channel may interrupt.
            cur_lvl_s = 5'(N_CH);
        end
        irq_pending_s = bus.ien & win_s.found & (win_lvl_s < cur_lvl_s);
        // 32-bit sum, then truncation gives the modulo-2^VEC_W wrap.
        vec_sum_s = 32'(VEC_BASE) + (32'(win_s.idx) * 32'(VEC_STRIDE));
        if (irq_pending_s) begin
            irq_vec_s = VEC_W'(vec_sum_s);
        end else begin
            irq_vec_s = VEC_BASE;
        end
    end

    // Next pending / in-service values from ack, eoi and fresh captures.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            win_oh_s[i] = win_s.found & (win_s.idx == 4'(i));
            cur_oh_s[i] = cur_s.found & (cur_s.idx == 4'(i));
        end
        ack_take_s = bus.int_ack & irq_pending_s;
        eoi_take_s = bus.int_eoi & cur_s.found;
        // Capture is OR-ed last so a same-edge capture beats the ack clear.
        pending_nx_s    = (pending_r & ~({N_CH{ack_take_s}} & win_oh_s)) | capture_s;
        // Ack and eoi never hit the same bit because the winner out-ranks c.
        in_service_nx_s = (in_service_r | ({N_CH{ack_take_s}} & win_oh_s))
                        & ~({N_CH{eoi_take_s}} & cur_oh_s);
    end

    // Configuration and interrupt state registers.
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            mask_r       <= {N_CH{1'b1}};
            mode_r       <= {N_CH{MODE_EDGE}};
            pending_r    <= {N_CH{1'b0}};
            in_service_r <= {N_CH{1'b0}};
        end else begin
            if (bus.mask_we) begin
                mask_r <= bus.mask_in;
            end
            if (bus.mode_we) begin
                mode_r <= bus.mode_in;
            end
            pending_r    <= pending_nx_s;
            in_service_r <= in_service_nx_s;
        end
    end

    assign bus.irq_pending = irq_pending_s;
    assign bus.irq_vec     = irq_vec_s;
    assign bus.pend_out    = pending_r;
    assign bus.in_service  = in_service_r;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vectored_int_ctrl
// Scoreboard bench: the stimulus process advances a behavioural model (pending
// set, in-service stack, delayed source history) and pushes the expected
// outputs for every cycle; a monitor pops and compares on the falling edge.
// A second instance (16 channels, base F8, stride 2) checks vector wrap.
// -----------------------------------------------------------------------------
module tb_vectored_int_ctrl;

    localparam int N = 4;

    typedef struct {
        logic       irq;
        logic [7:0] vec;
        logic [3:0] pend;
        logic [3:0] insvc;
        bit         chk2;
        logic       irq2;
        logic [7:0] vec2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vectored_int_ctrl_if #(.N_CH(4),  .VEC_W(8)) bus  ();
    vectored_int_ctrl_if #(.N_CH(16), .VEC_W(8)) bus2 ();

    vectored_int_ctrl #(.N_CH(4), .VEC_W(8), .VEC_BASE(8'hF0), .VEC_STRIDE(1)) dut (
        .g_clk (clk),
        .g_clr (rst),
        .bus   (bus)
    );

    vectored_int_ctrl #(.N_CH(16), .VEC_W(8), .VEC_BASE(8'hF8), .VEC_STRIDE(2)) dut2 (
        .g_clk (clk),
        .g_clr (rst),
        .bus   (bus2)
    );

    // scoreboard and counters
    exp_t sb_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    bit   stim_done = 1'b0;

    // behavioural model state
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic [3:0] m_mode;
    int         m_stack[$];   // channels in service, most recently accepted last
    logic [3:0] m_hist[$];    // source samples of the last three edges, oldest first

    // next-cycle stimulus
    logic        nx_rst;
    logic [3:0]  nx_src, nx_mask_in, nx_mode_in;
    logic        nx_mask_we, nx_mode_we, nx_ien, nx_ack, nx_eoi;
    logic [15:0] nx2_src;
    logic        nx2_mask_we, nx2_ien;
    bit          e2_chk;
    logic        e2_irq;
    logic [7:0]  e2_vec;

    task automatic model_reset();
        m_pend = 4'h0;
        m_mask = 4'hF;
        m_mode = 4'hF;
        m_stack.delete();
        m_hist.delete();
        for (int k = 0; k < 3; k++) m_hist.push_back(4'h0);
    endtask

    function automatic bit model_req(output int j);
        logic [3:0] elig;
        int c;
        elig = m_pend & ~m_mask;
        j = N;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) j = i;
        c = (m_stack.size() == 0) ? N : m_stack[$];
        return bus.ien && (j < N) && (j < c);
    endfunction

    function automatic logic [3:0] stack_bits();
        logic [3:0] r;
        r = 4'h0;
        foreach (m_stack[k]) r = r | (4'b0001 << m_stack[k]);
        return r;
    endfunction

    // One clock edge of the model, using the inputs the DUT sees at that edge.
    task automatic model_step();
        logic [3:0] cap;
        int j;
        bit req;
        if (rst) begin
            model_reset();
        end else begin
            req = model_req(j);
            for (int i = 0; i < N; i++)
                cap[i] = m_mode[i] ? (m_hist[1][i] & ~m_hist[0][i]) : m_hist[1][i];
            if (bus.int_eoi && m_stack.size() > 0) void'(m_stack.pop_back());
            if (bus.int_ack && req) begin
                m_pend[j[1:0]] = 1'b0;
                m_stack.push_back(j);
            end
            m_pend = m_pend | cap;
            if (bus.mask_we) m_mask = bus.mask_in;
            if (bus.mode_we) m_mode = bus.mode_in;
            m_hist.push_back(bus.int_src);
            void'(m_hist.pop_front());
        end
    endtask

    task automatic apply_inputs();
        rst           = nx_rst;
        bus.int_src   = nx_src;
        bus.mask_in   = nx_mask_in;
        bus.mask_we   = nx_mask_we;
        bus.mode_in   = nx_mode_in;
        bus.mode_we   = nx_mode_we;
        bus.ien       = nx_ien;
        bus.int_ack   = nx_ack;
        bus.int_eoi   = nx_eoi;
        bus2.int_src  = nx2_src;
        bus2.mask_in  = 16'h0000;
        bus2.mask_we  = nx2_mask_we;
        bus2.mode_in  = 16'hFFFF;
        bus2.mode_we  = 1'b0;
        bus2.ien      = nx2_ien;
        bus2.int_ack  = 1'b0;
        bus2.int_eoi  = 1'b0;
        if (rst) model_reset();
    endtask

    task automatic push_expect();
        exp_t e;
        int j;
        e.irq   = model_req(j);
        e.vec   = e.irq ? (8'hF0 + 8'(j)) : 8'hF0;
        e.pend  = m_pend;
        e.insvc = stack_bits();
        e.chk2  = e2_chk;
        e.irq2  = e2_irq;
        e.vec2  = e2_vec;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
        apply_inputs();
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic ack();
        nx_ack = 1'b1; step(); nx_ack = 1'b0;
    endtask

    task automatic eoi();
        nx_eoi = 1'b1; step(); nx_eoi = 1'b0;
    endtask

    task automatic pulse_src(input logic [3:0] s);
        nx_src = s; step(); nx_src = 4'h0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // monitor: compare DUT outputs against the scoreboard on the falling edge
    initial begin
        exp_t e;
        while (!stim_done) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("irq_pending", 32'(bus.irq_pending), 32'(e.irq));
                chk("irq_vec",     32'(bus.irq_vec),     32'(e.vec));
                chk("pend_out",    32'(bus.pend_out),    32'(e.pend));
                chk("in_service",  32'(bus.in_service),  32'(e.insvc));
                if (e.chk2) begin
                    chk("wide_irq_pending", 32'(bus2.irq_pending), 32'(e.irq2));
                    chk("wide_irq_vec",     32'(bus2.irq_vec),     32'(e.vec2));
                end
            end
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d/%0d so far", pass_cnt, check_cnt);
        $fatal(1);
    end

    // stimulus
    initial begin
        nx_rst = 1'b1; nx_src = 4'h0; nx_mask_in = 4'hF; nx_mode_in = 4'hF;
        nx_mask_we = 1'b0; nx_mode_we = 1'b0; nx_ien = 1'b0;
        nx_ack = 1'b0; nx_eoi = 1'b0;
        nx2_src = 16'h0000; nx2_mask_we = 1'b0; nx2_ien = 1'b0;
        e2_chk = 1'b1; e2_irq = 1'b0; e2_vec = 8'hF8;
        apply_inputs();
        idle(3);
        nx_rst = 1'b0;
        step();

        // wide instance: ch7 -> F8 + 7*2 wraps to 06
        nx2_mask_we = 1'b1; nx2_ien = 1'b1; step();
        nx2_mask_we = 1'b0; nx2_src = 16'h0080; idle(3);
        e2_irq = 1'b1; e2_vec = 8'h06; idle(3);
        e2_chk = 1'b0;

        // basic request, vector and accept on ch2
        nx_mask_in = 4'h0; nx_mask_we = 1'b1; nx_ien = 1'b1; step();
        nx_mask_we = 1'b0;
        pulse_src(4'b0100); idle(3); ack(); idle(2);

        // nesting: ch3 waits, ch1 pre-empts, eoi unwinds
        pulse_src(4'b1000); idle(3);
        pulse_src(4'b0010); idle(3);
        ack(); idle(1); eoi(); idle(1); eoi(); idle(1); ack(); idle(1); eoi(); idle(2);

        // level mode ch0 re-pends while held; edge mode single pulse does not
        nx_mode_in = 4'b1110; nx_mode_we = 1'b1; nx_src = 4'b0001; step();
        nx_mode_we = 1'b0; idle(4); ack(); idle(3);
        nx_src = 4'h0; idle(3); eoi(); idle(1); ack(); idle(1); eoi(); idle(1);
        nx_mode_in = 4'hF; nx_mode_we = 1'b1; step(); nx_mode_we = 1'b0;
        pulse_src(4'b0001); idle(3); ack(); idle(2); eoi(); idle(1);

        // mask holds a pending request, unmask re-raises, ien gates output
        nx_mask_in = 4'b0010; nx_mask_we = 1'b1; step(); nx_mask_we = 1'b0;
        pulse_src(4'b0010); idle(4);
        nx_mask_in = 4'h0; nx_mask_we = 1'b1; step(); nx_mask_we = 1'b0; idle(2);
        nx_ien = 1'b0; idle(3); nx_ien = 1'b1; idle(1);
        ack(); idle(1); eoi(); idle(1);

        // async reset between ack and eoi of a nested pair, pulses during reset
        pulse_src(4'b0100); idle(3); ack(); idle(1);
        pulse_src(4'b0001); idle(3); ack(); idle(1);
        nx_rst = 1'b1; nx_ack = 1'b1; step();
        nx_ack = 1'b0; nx_eoi = 1'b1; step();
        nx_eoi = 1'b0; idle(2);
        nx_rst = 1'b0; step(); idle(2);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            nx_src     = nx_src ^ (4'($urandom) & 4'($urandom));
            nx_ack     = ($urandom_range(0, 2) == 0);
            nx_eoi     = ($urandom_range(0, 4) == 0);
            nx_mask_we = ($urandom_range(0, 15) == 0);
            nx_mask_in = 4'($urandom) & 4'($urandom);
            nx_mode_we = ($urandom_range(0, 15) == 0);
            nx_mode_in = 4'($urandom);
            nx_ien     = ($urandom_range(0, 9) != 0);
            nx_rst     = ($urandom_range(0, 199) == 0);
            step();
        end

        nx_rst = 1'b0; nx_src = 4'h0; nx_ack = 1'b0; nx_eoi = 1'b0;
        nx_mask_we = 1'b0; nx_mode_we = 1'b0;
        idle(3);
        @(negedge clk);
        #1;
        stim_done = 1'b1;
    end

endmodule
